// File: rtl/pcie_rx_cpl_if.sv
// Bus bundle for pcie_rx_cpl: TRN receive stream, ORT request/allocation and memory write port.
// The block itself connects through the slave modport.
interface pcie_rx_cpl_if #(
    parameter int MEM_ADDR_BITS = 12
);
    logic [63:0]              trn_rd;
    logic [7:0]               trn_rrem_n;
    logic                     trn_rsof_n;
    logic                     trn_reof_n;
    logic                     trn_rsrc_rdy_n;
    logic                     trn_rdst_rdy_n;

    logic                     ort_req_v;
    logic [3:0]               ort_req_tag;
    logic [1:0]               ort_req_iface;
    logic [3:0]               ort_req_mem;
    logic [MEM_ADDR_BITS-1:0] ort_req_addr;
    logic                     ort_next_tag_v;
    logic [3:0]               ort_next_tag;

    logic                     mem_wr_v;
    logic [1:0]               mem_wr_iface;
    logic [3:0]               mem_wr_mem;
    logic [MEM_ADDR_BITS-1:0] mem_wr_addr;
    logic [63:0]              mem_wr_data;
    logic [1:0]               mem_wr_dw_en;
    logic                     cpl_err;

    modport slave (
        input  trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n,
        output trn_rdst_rdy_n,
        input  ort_req_v, ort_req_tag, ort_req_iface, ort_req_mem, ort_req_addr,
        output ort_next_tag_v, ort_next_tag,
        output mem_wr_v, mem_wr_iface, mem_wr_mem, mem_wr_addr, mem_wr_data, mem_wr_dw_en,
        output cpl_err
    );

    modport master (
        output trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n,
        input  trn_rdst_rdy_n,
        output ort_req_v, ort_req_tag, ort_req_iface, ort_req_mem, ort_req_addr,
        input  ort_next_tag_v, ort_next_tag,
        input  mem_wr_v, mem_wr_iface, mem_wr_mem, mem_wr_addr, mem_wr_data, mem_wr_dw_en,
        input  cpl_err
    );
endinterface

// File: rtl/pcie_rx_cpl.sv
// Receive completion engine: owns the 16-tag ORT and turns CplD payloads into DW memory writes.
// Optional macro PCIE_RX_CPL_STATUS_CHECK_EN enables completion status checking and Cpl handling.
module pcie_rx_cpl #(
    parameter int MEM_ADDR_BITS = 12
) (
    input  logic         pcie_clk,
    input  logic         rst,
    pcie_rx_cpl_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR2 = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

`ifdef PCIE_RX_CPL_STATUS_CHECK_EN
    localparam logic STATUS_CHECK = 1'b1;
`else
    localparam logic STATUS_CHECK = 1'b0;
`endif

    typedef logic [MEM_ADDR_BITS-1:0] addr_t;

    function automatic addr_t addr_add(input addr_t a, input logic [10:0] n);
        return a + addr_t'(n);
    endfunction

    logic [15:0] busy;
    logic [1:0]  ort_iface [16];
    logic [3:0]  ort_mem   [16];
    addr_t       ort_addr  [16];

    logic [1:0]  state, state_nxt;
    logic [10:0] len_p0, len_nxt;
    logic [12:0] bcnt_p0, bcnt_nxt;
    logic [2:0]  status_p0, status_nxt;
    logic        nodata_p0, nodata_nxt;
    logic [3:0]  tag_p0, tag_nxt;
    logic [1:0]  iface_p0, iface_nxt;
    logic [3:0]  mem_p0, mem_nxt;
    addr_t       addr_p0, addr_nxt;
    logic        pend_p0, pend_nxt;

    logic        wr_v;
    logic [1:0]  wr_en;
    logic [1:0]  wr_iface;
    logic [3:0]  wr_mem;
    addr_t       wr_addr;
    logic [63:0] wr_data;
    logic        ret_v, free_v, parse_err, req_err;
    logic [3:0]  ret_tag;
    logic [3:0]  free_idx;

    logic        vld_p1;
    logic [1:0]  dw_en_p1;
    logic [1:0]  iface_p1;
    logic [3:0]  mem_p1;
    addr_t       addr_p1;
    logic [63:0] data_p1;
    logic        err_p1;
    logic        next_tag_v_p1;
    logic [3:0]  next_tag_p1;

    logic        beat, sof, eof;
    logic        is_cpld, is_cpl, hdr_ok, fits, status_bad;
    logic [9:0]  len_raw;
    logic [11:0] bcnt_raw;
    logic [7:0]  hdr_tag;
    logic [3:0]  hdr_idx;

    assign beat       = ~bus.trn_rsrc_rdy_n;
    assign sof        = ~bus.trn_rsof_n;
    assign eof        = ~bus.trn_reof_n;
    assign is_cpld    = (bus.trn_rd[62:61] == 2'b10) && (bus.trn_rd[60:56] == 5'b01010);
    assign is_cpl     = (bus.trn_rd[62:61] == 2'b00) && (bus.trn_rd[60:56] == 5'b01010);
    assign len_raw    = bus.trn_rd[41:32];
    assign bcnt_raw   = bus.trn_rd[11:0];
    assign hdr_tag    = bus.trn_rd[47:40];
    assign hdr_idx    = hdr_tag[3:0];
    assign hdr_ok     = (hdr_tag[7:4] == 4'h0) && busy[hdr_idx];
    assign fits       = ({len_p0, 2'b00} >= bcnt_p0);
    assign status_bad = STATUS_CHECK && (status_p0 != 3'b000);
    assign req_err    = bus.ort_req_v && busy[bus.ort_req_tag];

    // Parser: decode the current beat into a write request and ORT retirement
    always_comb begin
        state_nxt  = state;
        len_nxt    = len_p0;
        bcnt_nxt   = bcnt_p0;
        status_nxt = status_p0;
        nodata_nxt = nodata_p0;
        tag_nxt    = tag_p0;
        iface_nxt  = iface_p0;
        mem_nxt    = mem_p0;
        addr_nxt   = addr_p0;
        pend_nxt   = pend_p0;
        wr_v       = 1'b0;
        wr_en      = 2'b00;
        wr_iface   = iface_p0;
        wr_mem     = mem_p0;
        wr_addr    = addr_p0;
        wr_data    = bus.trn_rd;
        ret_v      = 1'b0;
        free_v     = 1'b0;
        ret_tag    = tag_p0;
        parse_err  = 1'b0;
        if (beat) begin
            if (sof) begin
                // A new header always wins; an interrupted completion keeps its tag
                if (state == ST_HDR2 || state == ST_DATA)
                    parse_err = 1'b1;
                len_nxt    = (len_raw == 10'd0) ? 11'd1024 : {1'b0, len_raw};
                bcnt_nxt   = (bcnt_raw == 12'd0) ? 13'd4096 : {1'b0, bcnt_raw};
                status_nxt = bus.trn_rd[15:13];
                nodata_nxt = is_cpl;
                pend_nxt   = 1'b0;
                if (is_cpld || (STATUS_CHECK && is_cpl))
                    state_nxt = eof ? ST_IDLE : ST_HDR2;
                else
                    state_nxt = eof ? ST_IDLE : ST_DROP;
            end else begin
                case (state)
                    ST_HDR2: begin
                        tag_nxt   = hdr_idx;
                        state_nxt = eof ? ST_IDLE : ST_DROP;
                        if (nodata_p0) begin
                            if (hdr_ok) begin
                                free_v    = 1'b1;
                                ret_tag   = hdr_idx;
                                parse_err = 1'b1;
                            end
                        end else if (!hdr_ok) begin
                            parse_err = 1'b1;
                        end else if (status_bad) begin
                            parse_err = 1'b1;
                            if (eof) begin
                                free_v  = 1'b1;
                                ret_tag = hdr_idx;
                            end else begin
                                pend_nxt = 1'b1;
                            end
                        end else begin
                            iface_nxt = ort_iface[hdr_idx];
                            mem_nxt   = ort_mem[hdr_idx];
                            addr_nxt  = addr_add(ort_addr[hdr_idx], 11'd1);
                            wr_v      = 1'b1;
                            wr_en     = 2'b10;
                            wr_iface  = ort_iface[hdr_idx];
                            wr_mem    = ort_mem[hdr_idx];
                            wr_addr   = ort_addr[hdr_idx];
                            wr_data   = {bus.trn_rd[31:0], 32'h0};
                            ret_tag   = hdr_idx;
                            if (eof) begin
                                ret_v  = 1'b1;
                                free_v = fits;
                            end else begin
                                state_nxt = ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        wr_v = 1'b1;
                        if (eof && bus.trn_rrem_n == 8'h0f) begin
                            wr_en    = 2'b10;
                            addr_nxt = addr_add(addr_p0, 11'd1);
                        end else begin
                            wr_en    = 2'b11;
                            addr_nxt = addr_add(addr_p0, 11'd2);
                        end
                        if (eof) begin
                            ret_v     = 1'b1;
                            free_v    = fits;
                            state_nxt = ST_IDLE;
                        end
                    end
                    ST_DROP: begin
                        if (eof) begin
                            free_v    = pend_p0;
                            pend_nxt  = 1'b0;
                            state_nxt = ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge pcie_clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            len_p0    <= '0;
            bcnt_p0   <= '0;
            status_p0 <= '0;
            nodata_p0 <= 1'b0;
            tag_p0    <= '0;
            iface_p0  <= '0;
            mem_p0    <= '0;
            addr_p0   <= '0;
            pend_p0   <= 1'b0;
        end else begin
            state     <= state_nxt;
            len_p0    <= len_nxt;
            bcnt_p0   <= bcnt_nxt;
            status_p0 <= status_nxt;
            nodata_p0 <= nodata_nxt;
            tag_p0    <= tag_nxt;
            iface_p0  <= iface_nxt;
            mem_p0    <= mem_nxt;
            addr_p0   <= addr_nxt;
            pend_p0   <= pend_nxt;
        end
    end

    // ORT: a same-cycle registration is written last so it overrides a retirement
    always_ff @(posedge pcie_clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            for (int i = 0; i < 16; i++) begin
                ort_iface[i] <= '0;
                ort_mem[i]   <= '0;
                ort_addr[i]  <= '0;
            end
        end else begin
            if (free_v)
                busy[ret_tag] <= 1'b0;
            if (ret_v)
                ort_addr[ret_tag] <= addr_add(ort_addr[ret_tag], len_p0);
            if (bus.ort_req_v) begin
                busy[bus.ort_req_tag]      <= 1'b1;
                ort_iface[bus.ort_req_tag] <= bus.ort_req_iface;
                ort_mem[bus.ort_req_tag]   <= bus.ort_req_mem;
                ort_addr[bus.ort_req_tag]  <= bus.ort_req_addr;
            end
        end
    end

    always_comb begin
        free_idx = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (!busy[i])
                free_idx = 4'(i);
    end

    // Output stage: registered write port, error pulse and free-tag report
    always_ff @(posedge pcie_clk or posedge rst) begin
        if (rst) begin
            vld_p1        <= 1'b0;
            dw_en_p1      <= '0;
            iface_p1      <= '0;
            mem_p1        <= '0;
            addr_p1       <= '0;
            data_p1       <= '0;
            err_p1        <= 1'b0;
            next_tag_v_p1 <= 1'b1;
            next_tag_p1   <= '0;
        end else begin
            vld_p1        <= wr_v;
            dw_en_p1      <= wr_en;
            err_p1        <= parse_err | req_err;
            next_tag_v_p1 <= ~&busy;
            next_tag_p1   <= free_idx;
            if (wr_v) begin
                iface_p1 <= wr_iface;
                mem_p1   <= wr_mem;
                addr_p1  <= wr_addr;
                data_p1  <= wr_data;
            end
        end
    end

    assign bus.trn_rdst_rdy_n = rst;
    assign bus.ort_next_tag_v = next_tag_v_p1;
    assign bus.ort_next_tag   = next_tag_p1;
    assign bus.mem_wr_v       = vld_p1;
    assign bus.mem_wr_dw_en   = dw_en_p1;
    assign bus.mem_wr_iface   = iface_p1;
    assign bus.mem_wr_mem     = mem_p1;
    assign bus.mem_wr_addr    = addr_p1;
    assign bus.mem_wr_data    = data_p1;
    assign bus.cpl_err        = err_p1;
endmodule

// File: tb/tb_pcie_rx_cpl.sv
// Directed bench for pcie_rx_cpl: CplD parsing, split completions, tag allocation, drops, reset.
// Status-field expectations follow PCIE_RX_CPL_STATUS_CHECK_EN.
module tb_pcie_rx_cpl;
    localparam int AW = 12;

    logic pcie_clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [84:0] want;

    pcie_rx_cpl_if #(.MEM_ADDR_BITS(AW)) bus ();

    pcie_rx_cpl #(.MEM_ADDR_BITS(AW)) dut (
        .pcie_clk (pcie_clk),
        .rst      (rst),
        .bus      (bus)
    );

    initial pcie_clk = 1'b0;
    always #5 pcie_clk = ~pcie_clk;

    function automatic logic [84:0] wr_obs();
        return {bus.mem_wr_v, bus.mem_wr_dw_en, bus.mem_wr_iface, bus.mem_wr_mem,
                bus.mem_wr_addr, bus.mem_wr_data};
    endfunction

    function automatic logic [63:0] hdr(input logic [1:0] fmt, input logic [4:0] typ,
                                        input logic [9:0] len, input logic [2:0] st,
                                        input logic [11:0] bc);
        logic [63:0] d;
        d = '0;
        d[62:61] = fmt;
        d[60:56] = typ;
        d[41:32] = len;
        d[15:13] = st;
        d[11:0]  = bc;
        return d;
    endfunction

    function automatic logic [63:0] dw2(input logic [7:0] tag, input logic [31:0] p);
        logic [63:0] d;
        d = '0;
        d[47:40] = tag;
        d[31:0]  = p;
        return d;
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic s, input logic e,
                             input logic [7:0] rrem_n);
        bus.trn_rd         = d;
        bus.trn_rsof_n     = ~s;
        bus.trn_reof_n     = ~e;
        bus.trn_rrem_n     = rrem_n;
        bus.trn_rsrc_rdy_n = 1'b0;
        @(posedge pcie_clk);
        #1;
        bus.trn_rsrc_rdy_n = 1'b1;
        bus.trn_rsof_n     = 1'b1;
        bus.trn_reof_n     = 1'b1;
    endtask

    task automatic idle_cycle();
        @(posedge pcie_clk);
        #1;
    endtask

    task automatic ort_reg(input logic [3:0] tag, input logic [1:0] ifc, input logic [3:0] mem,
                           input logic [AW-1:0] addr);
        bus.ort_req_v     = 1'b1;
        bus.ort_req_tag   = tag;
        bus.ort_req_iface = ifc;
        bus.ort_req_mem   = mem;
        bus.ort_req_addr  = addr;
        @(posedge pcie_clk);
        #1;
        bus.ort_req_v = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.trn_rdst_rdy_n, bus.ort_next_tag_v, bus.ort_next_tag, bus.cpl_err} !== 7'b1_1_0000_0) begin
            miscompares++;
            $display("FAIL reset_ctrl got=%b want=1100000",
                     {bus.trn_rdst_rdy_n, bus.ort_next_tag_v, bus.ort_next_tag, bus.cpl_err});
        end
        vectors++;
        if (wr_obs() !== '0) begin
            miscompares++;
            $display("FAIL reset_wr got=%h want=0", wr_obs());
        end
        repeat (2) @(posedge pcie_clk);
        #1;
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.trn_rdst_rdy_n !== 1'b0) begin
            miscompares++;
            $display("FAIL rdst_rdy_after_reset got=%b want=0", bus.trn_rdst_rdy_n);
        end
        idle_cycle();
    endtask

    task automatic test_basic();
        ort_reg(4'd0, 2'd1, 4'd2, 12'h010);
        send_beat(hdr(2'b10, 5'b01010, 10'd4, 3'b000, 12'd16), 1'b1, 1'b0, 8'h00);
        vectors++;
        if (bus.mem_wr_v !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_hdr_nowrite got=%b want=0", bus.mem_wr_v);
        end
        send_beat(dw2(8'd0, 32'hAAAA_0001), 1'b0, 1'b0, 8'h00);
        want = {1'b1, 2'b10, 2'd1, 4'd2, 12'h010, 32'hAAAA_0001, 32'h0};
        vectors++;
        if (wr_obs() !== want) begin
            miscompares++;
            $display("FAIL basic_w0 got=%h want=%h", wr_obs(), want);
        end
        send_beat({32'hBBBB_0002, 32'hCCCC_0003}, 1'b0, 1'b0, 8'h00);
        want = {1'b1, 2'b11, 2'd1, 4'd2, 12'h011, 32'hBBBB_0002, 32'hCCCC_0003};
        vectors++;
        if (wr_obs() !== want) begin
            miscompares++;
            $display("FAIL basic_w1 got=%h want=%h", wr_obs(), want);
        end
        send_beat({32'hDDDD_0004, 32'h0}, 1'b0, 1'b1, 8'h0f);
        want = {1'b1, 2'b10, 2'd1, 4'd2, 12'h013, 32'hDDDD_0004, 32'h0};
        vectors++;
        if (wr_obs() !== want) begin
            miscompares++;
            $display("FAIL basic_w2 got=%h want=%h", wr_obs(), want);
        end
        vectors++;
        if (bus.ort_next_tag !== 4'd1) begin
            miscompares++;
            $display("FAIL basic_tag_still_busy got=%0d want=1", bus.ort_next_tag);
        end
        idle_cycle();
        vectors++;
        if ({bus.mem_wr_v, bus.ort_next_tag_v, bus.ort_next_tag} !== 6'b0_1_0000) begin
            miscompares++;
            $display("FAIL basic_freed got=%b want=010000",
                     {bus.mem_wr_v, bus.ort_next_tag_v, bus.ort_next_tag});
        end
    endtask

    task automatic test_split_back_to_back();
        ort_reg(4'd0, 2'd0, 4'd0, 12'h000);
        ort_reg(4'd1, 2'd0, 4'd0, 12'h000);
        ort_reg(4'd2, 2'd0, 4'd0, 12'h000);
        ort_reg(4'd3, 2'd2, 4'd5, 12'h020);
        send_beat(hdr(2'b10, 5'b01010, 10'd2, 3'b000, 12'd16), 1'b1, 1'b0, 8'h00);
        send_beat(dw2(8'd3, 32'h1111_0000), 1'b0, 1'b0, 8'h00);
        want = {1'b1, 2'b10, 2'd2, 4'd5, 12'h020, 32'h1111_0000, 32'h0};
        vectors++;
        if (wr_obs() !== want) begin
            miscompares++;
            $display("FAIL split_a0 got=%h want=%h", wr_obs(), want);
        end
        send_beat({32'h1111_0001, 32'h0}, 1'b0, 1'b1, 8'h0f);
        want = {1'b1, 2'b10, 2'd2, 4'd5, 12'h021, 32'h1111_0001, 32'h0};
        vectors++;
        if (wr_obs() !== want) begin
            miscompares++;
            $display("FAIL split_a1 got=%h want=%h", wr_obs(), want);
        end
        send_beat(hdr(2'b10, 5'b01010, 10'd2, 3'b000, 12'd8), 1'b1, 1'b0, 8'h00);
        vectors++;
        if ({bus.mem_wr_v, bus.cpl_err, bus.ort_next_tag} !== 6'b0_0_0100) begin
            miscompares++;
            $display("FAIL split_b2b_hdr got=%b want=000100",
                     {bus.mem_wr_v, bus.cpl_err, bus.ort_next_tag});
        end
        send_beat(dw2(8'd3, 32'h2222_0000), 1'b0, 1'b0, 8'h00);
        want = {1'b1, 2'b10, 2'd2, 4'd5, 12'h022, 32'h2222_0000, 32'h0};
        vectors++;
        if (wr_obs() !== want) begin
            miscompares++;
            $display("FAIL split_b0 got=%h want=%h", wr_obs(), want);
        end
        send_beat({32'h2222_0001, 32'h0}, 1'b0, 1'b1, 8'h0f);
        want = {1'b1, 2'b10, 2'd2, 4'd5, 12'h023, 32'h2222_0001, 32'h0};
        vectors++;
        if (wr_obs() !== want) begin
            miscompares++;
            $display("FAIL split_b1 got=%h want=%h", wr_obs(), want);
        end
        idle_cycle();
        idle_cycle();
        vectors++;
        if (bus.ort_next_tag !== 4'd3) begin
            miscompares++;
            $display("FAIL split_freed got=%0d want=3", bus.ort_next_tag);
        end
    endtask

    task automatic test_drop();
        send_beat(hdr(2'b10, 5'b01010, 10'd1, 3'b000, 12'd4), 1'b1, 1'b0, 8'h00);
        send_beat(dw2(8'd7, 32'h7777_7777), 1'b0, 1'b1, 8'h0f);
        vectors++;
        if ({bus.mem_wr_v, bus.cpl_err} !== 2'b01) begin
            miscompares++;
            $display("FAIL drop_nonbusy got=%b want=01", {bus.mem_wr_v, bus.cpl_err});
        end
        idle_cycle();
        vectors++;
        if (bus.cpl_err !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_err_pulse got=%b want=0", bus.cpl_err);
        end
        send_beat(hdr(2'b10, 5'b00000, 10'd1, 3'b000, 12'd0), 1'b1, 1'b0, 8'h00);
        send_beat({32'h0000_0100, 32'h0000_0000}, 1'b0, 1'b0, 8'h00);
        send_beat({32'h0101_0101, 32'h0}, 1'b0, 1'b1, 8'h0f);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({bus.mem_wr_v, bus.cpl_err} !== 2'b00) begin
                miscompares++;
                $display("FAIL drop_mwr step%0d got=%b want=00", i, {bus.mem_wr_v, bus.cpl_err});
            end
            idle_cycle();
        end
    endtask

    task automatic test_status();
        ort_reg(4'd6, 2'd3, 4'd1, 12'h040);
        send_beat(hdr(2'b10, 5'b01010, 10'd2, 3'b001, 12'd8), 1'b1, 1'b0, 8'h00);
        send_beat(dw2(8'd6, 32'h6666_0000), 1'b0, 1'b0, 8'h00);
`ifdef PCIE_RX_CPL_STATUS_CHECK_EN
        vectors++;
        if ({bus.mem_wr_v, bus.cpl_err} !== 2'b01) begin
            miscompares++;
            $display("FAIL status_drop got=%b want=01", {bus.mem_wr_v, bus.cpl_err});
        end
`else
        want = {1'b1, 2'b10, 2'd3, 4'd1, 12'h040, 32'h6666_0000, 32'h0};
        vectors++;
        if (wr_obs() !== want || bus.cpl_err !== 1'b0) begin
            miscompares++;
            $display("FAIL status_ignored_w0 got=%h err=%b want=%h err=0", wr_obs(), bus.cpl_err, want);
        end
`endif
        send_beat({32'h6666_0001, 32'h0}, 1'b0, 1'b1, 8'h0f);
`ifdef PCIE_RX_CPL_STATUS_CHECK_EN
        vectors++;
        if ({bus.mem_wr_v, bus.cpl_err} !== 2'b00) begin
            miscompares++;
            $display("FAIL status_drop_eof got=%b want=00", {bus.mem_wr_v, bus.cpl_err});
        end
`else
        want = {1'b1, 2'b10, 2'd3, 4'd1, 12'h041, 32'h6666_0001, 32'h0};
        vectors++;
        if (wr_obs() !== want) begin
            miscompares++;
            $display("FAIL status_ignored_w1 got=%h want=%h", wr_obs(), want);
        end
`endif
        idle_cycle();
    endtask

    task automatic test_alloc();
        for (int i = 0; i < 16; i++) begin
            ort_reg(4'(i), 2'(i), 4'(i), 12'(i * 16));
            vectors++;
            if (bus.cpl_err !== (i < 3)) begin
                miscompares++;
                $display("FAIL alloc_err tag%0d got=%b want=%b", i, bus.cpl_err, (i < 3));
            end
        end
        idle_cycle();
        vectors++;
        if (bus.ort_next_tag_v !== 1'b0) begin
            miscompares++;
            $display("FAIL alloc_full got=%b want=0", bus.ort_next_tag_v);
        end
        send_beat(hdr(2'b10, 5'b01010, 10'd1, 3'b000, 12'd4), 1'b1, 1'b0, 8'h00);
        send_beat(dw2(8'd5, 32'h5555_0005), 1'b0, 1'b1, 8'h0f);
        want = {1'b1, 2'b10, 2'd1, 4'd5, 12'h050, 32'h5555_0005, 32'h0};
        vectors++;
        if (wr_obs() !== want || bus.ort_next_tag_v !== 1'b0) begin
            miscompares++;
            $display("FAIL alloc_free5_w got=%h v=%b want=%h v=0", wr_obs(), bus.ort_next_tag_v, want);
        end
        idle_cycle();
        vectors++;
        if ({bus.ort_next_tag_v, bus.ort_next_tag} !== 5'b1_0101) begin
            miscompares++;
            $display("FAIL alloc_next5 got=%b want=10101", {bus.ort_next_tag_v, bus.ort_next_tag});
        end
    endtask

    task automatic test_reset_mid();
        send_beat(hdr(2'b10, 5'b01010, 10'd16, 3'b000, 12'd64), 1'b1, 1'b0, 8'h00);
        send_beat(dw2(8'd9, 32'h9999_0000), 1'b0, 1'b0, 8'h00);
        want = {1'b1, 2'b10, 2'd1, 4'd9, 12'h090, 32'h9999_0000, 32'h0};
        vectors++;
        if (wr_obs() !== want) begin
            miscompares++;
            $display("FAIL rstmid_w0 got=%h want=%h", wr_obs(), want);
        end
        send_beat({32'h9999_0001, 32'h9999_0002}, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        #1;
        vectors++;
        if (wr_obs() !== '0 ||
            {bus.cpl_err, bus.trn_rdst_rdy_n, bus.ort_next_tag_v, bus.ort_next_tag} !== 7'b0_1_1_0000) begin
            miscompares++;
            $display("FAIL rstmid_values got=%h ctrl=%b want=0 ctrl=0110000", wr_obs(),
                     {bus.cpl_err, bus.trn_rdst_rdy_n, bus.ort_next_tag_v, bus.ort_next_tag});
        end
        @(posedge pcie_clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send_beat({32'h9999_1000 + 32'(i), 32'h9999_2000 + 32'(i)}, 1'b0, (i == 6), 8'h0f);
            vectors++;
            if (bus.mem_wr_v !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid_tail beat%0d got=%b want=0", i, bus.mem_wr_v);
            end
        end
        ort_reg(4'd0, 2'd2, 4'd3, 12'hfff);
        send_beat(hdr(2'b10, 5'b01010, 10'd3, 3'b000, 12'd12), 1'b1, 1'b0, 8'h00);
        vectors++;
        if (bus.ort_next_tag !== 4'd1) begin
            miscompares++;
            $display("FAIL rstmid_reg got=%0d want=1", bus.ort_next_tag);
        end
        send_beat(dw2(8'd0, 32'hE000_0000), 1'b0, 1'b0, 8'h00);
        want = {1'b1, 2'b10, 2'd2, 4'd3, 12'hfff, 32'hE000_0000, 32'h0};
        vectors++;
        if (wr_obs() !== want) begin
            miscompares++;
            $display("FAIL rstmid_clean_w0 got=%h want=%h", wr_obs(), want);
        end
        send_beat({32'hE000_0001, 32'hE000_0002}, 1'b0, 1'b1, 8'h00);
        want = {1'b1, 2'b11, 2'd2, 4'd3, 12'h000, 32'hE000_0001, 32'hE000_0002};
        vectors++;
        if (wr_obs() !== want) begin
            miscompares++;
            $display("FAIL rstmid_clean_wrap got=%h want=%h", wr_obs(), want);
        end
        idle_cycle();
        vectors++;
        if ({bus.mem_wr_v, bus.ort_next_tag} !== 5'b0_0000) begin
            miscompares++;
            $display("FAIL rstmid_clean_free got=%b want=00000", {bus.mem_wr_v, bus.ort_next_tag});
        end
    endtask

    initial begin
        vectors            = 0;
        miscompares        = 0;
        want               = '0;
        rst                = 1'b1;
        bus.trn_rd         = '0;
        bus.trn_rrem_n     = 8'h00;
        bus.trn_rsof_n     = 1'b1;
        bus.trn_reof_n     = 1'b1;
        bus.trn_rsrc_rdy_n = 1'b1;
        bus.ort_req_v      = 1'b0;
        bus.ort_req_tag    = '0;
        bus.ort_req_iface  = '0;
        bus.ort_req_mem    = '0;
        bus.ort_req_addr   = '0;
        test_reset();
        test_basic();
        test_split_back_to_back();
        test_drop();
        test_status();
        test_alloc();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pcie_rx_cpl.md
# pcie_rx_cpl

Receive-side completion engine for the DMA PCIe path: tracks outstanding memory-read tags, parses CplD TLPs arriving on the 64-bit TRN receive interface, and turns their payload into DW-addressed writes into the selected interface/memory. It sits beside the read-request transmitter. It owns the 16-entry outstanding-request table (ORT) that the transmitter allocates tags from and registers requests into. Each tag is released once the final completion for it has arrived.

## Interface
Parameters:
- MEM_ADDR_BITS, 12, width of the DW-granular local memory address.

Ports:
- pcie_clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- trn_rd  in  64  RX data; DW0 of each beat in [63:32].
- trn_rrem_n  in  8  RX remainder; 'h0f means only [63:32] is valid on the EOF beat.
- trn_rsof_n / trn_reof_n / trn_rsrc_rdy_n  in  1 each  RX framing, active-low.
- trn_rdst_rdy_n  out  1  always 0 outside reset; this block never backpressures.
- ort_req_v  in  1  register a new outstanding read.
- ort_req_tag  in  4  tag being registered.
- ort_req_iface  in  2  destination interface.
- ort_req_mem  in  4  destination memory select.
- ort_req_addr  in  MEM_ADDR_BITS  destination start DW address.
- ort_next_tag_v  out  1  at least one tag is free.
- ort_next_tag  out  4  lowest-numbered free tag.
- mem_wr_v  out  1  write strobe.
- mem_wr_iface  out  2  target interface.
- mem_wr_mem  out  4  target memory.
- mem_wr_addr  out  MEM_ADDR_BITS  address of DW in mem_wr_data[63:32].
- mem_wr_data  out  64  two DWs, upper DW at addr, lower DW at addr+1.
- mem_wr_dw_en  out  2  [1] enables the upper DW, [0] enables the lower DW.
- cpl_err  out  1  one-cycle pulse on a protocol or status error.

## Operation
- ORT state: 16 entries of {busy, iface, mem, addr}.
  - ort_req_v sets busy[tag] and loads the entry fields.
  - If ort_req_v targets a busy tag, the entry is overwritten and cpl_err pulses.
- Parser FSM, advancing only on beats where trn_rsrc_rdy_n=0:
  - IDLE: a beat with trn_rsof_n=0 latches DW0/DW1. From DW0 take fmt[62:61], type[60:56] and length[41:32] (0 means 1024). From DW1 take status[15:13] and byte_count[11:0] (0 means 4096).
    - fmt=2'b10 and type=5'b01010 (CplD) -> HDR2.
    - Any other TLP -> DROP, silently (other RX consumers own those TLPs).
  - HDR2: tag = trn_rd[47:40].
    - If tag[7:4]!=0 or busy[tag[3:0]]=0 -> DROP with a cpl_err pulse.
    - Otherwise write payload DW0 (trn_rd[31:0]) at entry.addr as mem_wr_data[63:32] with dw_en=2'b10, then go to DATA, or to IDLE if reof.
  - DATA: each beat writes two DWs at the running address. The EOF beat with trn_rrem_n='h0f uses dw_en=2'b10. The running address advances by the DW count written.
  - DROP: discard beats until reof, then IDLE.
  - A SOF beat seen in HDR2/DATA: cpl_err pulses, the current TLP is abandoned without freeing its tag, and the new TLP is parsed as if from IDLE.
- Completion retirement, at reof of an accepted CplD:
  - entry.addr += length (wraps modulo 2^MEM_ADDR_BITS).
  - If byte_count <= length*4, busy[tag] is cleared.
- Simultaneous events:
  - An ort_req_v and a retirement in the same cycle both take effect.
  - If both address the same tag, the ort_req_v wins: entry reloaded, busy stays set.
- Address arithmetic is MEM_ADDR_BITS wide and wraps with no flag.

## Timing
- Reset values:
  - trn_rdst_rdy_n=1 during reset, then 0.
  - Parser state IDLE; all busy bits 0.
  - ort_next_tag_v=1, ort_next_tag=0.
  - mem_wr_v=0, mem_wr_dw_en=0, mem_wr_data=0, mem_wr_addr=0, mem_wr_iface=0, mem_wr_mem=0.
  - cpl_err=0.
- mem_* outputs are registered: the write appears one cycle after its beat is accepted. At most one write per cycle; no write is issued for gap cycles.
- busy updates take effect on the cycle after ort_req_v or after the reof beat.
- ort_next_tag and ort_next_tag_v are registered from busy, so they reflect a change two cycles after the causing event.
- The parser is fully pipelined: back-to-back TLPs (reof followed immediately by sof) run with no bubble.
- Reset asserted mid-TLP: all state clears. The remaining beats of that TLP are discarded because IDLE ignores beats without SOF.

## Configuration
- Macro PCIE_RX_CPL_STATUS_CHECK_EN.
- Defined:
  - A CplD with status!=3'b000 -> DROP, cpl_err pulses, and busy[tag] is cleared at reof regardless of byte_count.
  - A Cpl without data (fmt=2'b00, type=5'b01010) for a busy tag also clears busy and pulses cpl_err.
- Undefined: the status field is ignored, and Cpl without data is dropped silently.

## Test plan
- Register tag 0 (iface 1, mem 2, addr 'h010), then send a CplD with length 4, byte_count 16 and payload A,B,C,D -> writes {A}@'h010 en 10, {B,C}@'h011 en 11, {D}@'h013 en 10 (rrem_n 'h0f); tag 0 is freed and ort_next_tag returns to 0.
- Split completion: tag 3, length 2 then length 2, byte_counts 16 then 8 -> second TLP data lands at addr+2; tag 3 stays busy after the first TLP and is freed after the second.
- Allocate tags 0..15 -> ort_next_tag_v=0; free tag 5 -> ort_next_tag=5, ort_next_tag_v=1 two cycles after reof.
- CplD for non-busy tag 7, and a memory-write TLP (fmt 2'b10, type 0) -> no mem_wr_v; cpl_err pulses only for the CplD.
- Status 3'b001 with the macro defined -> no writes, cpl_err pulses, tag freed. Same stimulus with the macro undefined -> data written normally.
- Assert rst during DATA of a 16-DW CplD -> outputs at reset values, no further writes; the next clean CplD is handled correctly.
